reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 8 +
 rtl/reg_scoreboard.sv | 60 ++++++
 rtl/reg_file_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer bit per register plus a registered population count.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      iAddr,
  input  logic                   iEna,
  input  logic [ADDR_W-1:0]      wAddr,
  input  logic                   wEna,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pendCnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_d;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_cnt_d;

  always_comb begin
    w_pend_d = r_pend;
    if (wEna && (wAddr != ADDR_W'(ZERO_REG))) begin
      w_pend_d[wAddr] = 1'b0;
    end
    // Issue applied after writeback so a new producer wins a same-address collision.
    if (iEna && (iAddr != ADDR_W'(ZERO_REG))) begin
      w_pend_d[iAddr] = 1'b1;
    end
    if (flush) begin
      w_pend_d = '0;
    end
    w_pend_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    w_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_d = w_cnt_d + (ADDR_W+1)'(w_pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign pend    = r_pend;
  assign pendCnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write forwarding and a producer scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rDout1,
  output logic [DATA_W-1:0] rDout2,
  output logic              rBusy1,
  output logic              rBusy2,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wDin,
  input  logic              wEna,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              iEna,
  input  logic              flush,
  output logic [ADDR_W:0]   pendCnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_pend;
  logic              w_wr_ok;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_zero1;
  logic              w_zero2;

  assign w_wr_ok = wEna && (wAddr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wAddr] <= wDin;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .iAddr   (iAddr),
    .iEna    (iEna),
    .wAddr   (wAddr),
    .wEna    (wEna),
    .flush   (flush),
    .pend    (w_pend),
    .pendCnt (pendCnt)
  );

  always_comb begin
    w_zero1 = (rAddr1 == ADDR_W'(ZERO_REG));
    w_zero2 = (rAddr2 == ADDR_W'(ZERO_REG));
    w_fwd1  = (BYPASS != 0) && w_wr_ok && (wAddr == rAddr1);
    w_fwd2  = (BYPASS != 0) && w_wr_ok && (wAddr == rAddr2);

    rDout1 = r_mem[rAddr1];
    if (w_zero1)     rDout1 = '0;
    else if (w_fwd1) rDout1 = wDin;

    rDout2 = r_mem[rAddr2];
    if (w_zero2)     rDout2 = '0;
    else if (w_fwd2) rDout2 = wDin;

    // A forwarded value resolves the hazard this cycle.
    rBusy1 = w_pend[rAddr1] && !w_fwd1 && !w_zero1;
    rBusy2 = w_pend[rAddr2] && !w_fwd2 && !w_zero2;
  end

endmodule
